// File: rtl/ldst_unit.sv
// Load/store execution stage: effective-address generation, an in-order store
// buffer drained to data memory after commit, and store-to-load forwarding.
module ldst_unit #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue_vld,
    output logic              o_issue_rdy,
    input  logic [DATA_W-1:0] i_rs1_srcopr,
    input  logic [DATA_W-1:0] i_rs2_srcopr,
    input  logic [DATA_W-1:0] i_imm,
    input  logic              i_is_st,
    input  logic [TAG_W-1:0]  i_rrftag,
    input  logic [1:0]        i_com_st_num,
    input  logic              i_flush,
    output logic              o_exfin_ld,
    output logic [TAG_W-1:0]  o_ex_ld_rrftag,
    output logic [DATA_W-1:0] o_exfin_ld_res,
    output logic              o_exfin_st,
    output logic [TAG_W-1:0]  o_ex_st_rrftag,
    output logic              o_dmem_rd_en,
    output logic [DATA_W-1:0] o_dmem_raddr,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    output logic              o_dmem_wr_en,
    output logic [DATA_W-1:0] o_dmem_waddr,
    output logic [DATA_W-1:0] o_dmem_wdata
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int WA_W  = DATA_W - 2;
    localparam int CNT_W = PTR_W + 1;

    logic [WA_W-1:0]   sb_addr_r [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_r [SB_DEPTH];
    logic [PTR_W-1:0]  head_r, tail_r, com_ptr_r;
    logic [CNT_W-1:0]  count_r, ucnt_r;

    logic              s1_vld_r, s2_vld_r, s2_hit_r, st_vld_r;
    logic [WA_W-1:0]   s1_addr_r;
    logic [TAG_W-1:0]  s1_tag_r, s2_tag_r, st_tag_r;
    logic [DATA_W-1:0] s2_fwd_r;

    logic              fire_s, alloc_s, ld_fire_s, drain_s, hit_s;
    logic [DATA_W-1:0] ea_s, fwd_s;
    logic [CNT_W-1:0]  ccnt_s, ucnt_left_s;
    logic [PTR_W-1:0]  com_ptr_nxt_s;

    // Issue handshake, address generation and commit bookkeeping
    always_comb begin
        o_issue_rdy   = (count_r < CNT_W'(SB_DEPTH)) && !i_flush;
        fire_s        = i_issue_vld && o_issue_rdy;
        alloc_s       = fire_s && i_is_st;
        ld_fire_s     = fire_s && !i_is_st;
        ea_s          = i_rs1_srcopr + i_imm;
        ccnt_s        = count_r - ucnt_r;
        drain_s       = (ccnt_s != '0);
        ucnt_left_s   = ucnt_r - CNT_W'(i_com_st_num);
        com_ptr_nxt_s = com_ptr_r + PTR_W'(i_com_st_num);
    end

    // Walk oldest to youngest so the last match seen is the youngest store
    always_comb begin
        hit_s = 1'b0;
        fwd_s = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CNT_W'(i) < count_r) && (sb_addr_r[head_r + PTR_W'(i)] == s1_addr_r)) begin
                hit_s = 1'b1;
                fwd_s = sb_data_r[head_r + PTR_W'(i)];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Store buffer payload; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            sb_addr_r[tail_r] <= ea_s[DATA_W-1:2];
            sb_data_r[tail_r] <= i_rs2_srcopr;
        end
    end

    // Store buffer pointers and occupancy; flush rewinds tail to the commit point
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r    <= '0;
            tail_r    <= '0;
            com_ptr_r <= '0;
            count_r   <= '0;
            ucnt_r    <= '0;
        end else begin
            head_r    <= head_r + PTR_W'(drain_s);
            com_ptr_r <= com_ptr_nxt_s;
            if (i_flush) begin
                tail_r  <= com_ptr_nxt_s;
                ucnt_r  <= '0;
                count_r <= count_r - ucnt_left_s - CNT_W'(drain_s);
            end else begin
                tail_r  <= tail_r + PTR_W'(alloc_s);
                ucnt_r  <= ucnt_left_s + CNT_W'(alloc_s);
                count_r <= count_r + CNT_W'(alloc_s) - CNT_W'(drain_s);
            end
        end
    end

    // Load pipeline stages and store completion register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_r  <= 1'b0;
            s1_addr_r <= '0;
            s1_tag_r  <= '0;
            s2_vld_r  <= 1'b0;
            s2_tag_r  <= '0;
            s2_hit_r  <= 1'b0;
            s2_fwd_r  <= '0;
            st_vld_r  <= 1'b0;
            st_tag_r  <= '0;
        end else begin
            s1_vld_r  <= ld_fire_s;
            s1_addr_r <= ea_s[DATA_W-1:2];
            s1_tag_r  <= i_rrftag;
            s2_vld_r  <= s1_vld_r && !i_flush;
            s2_tag_r  <= s1_tag_r;
            s2_hit_r  <= hit_s;
            s2_fwd_r  <= fwd_s;
            st_vld_r  <= alloc_s;
            st_tag_r  <= alloc_s ? i_rrftag : st_tag_r;
        end
    end

    // Completion broadcasts and data-memory request signals
    always_comb begin
        o_exfin_st     = st_vld_r;
        o_ex_st_rrftag = st_tag_r;
        o_exfin_ld     = s2_vld_r;
        o_ex_ld_rrftag = s2_tag_r;
        if (!s2_vld_r) begin
            o_exfin_ld_res = '0;
        end else if (s2_hit_r) begin
            o_exfin_ld_res = s2_fwd_r;
        end else begin
            o_exfin_ld_res = i_dmem_rdata;
        end
        o_dmem_rd_en = s1_vld_r && !hit_s;
        if (o_dmem_rd_en) begin
            o_dmem_raddr = {s1_addr_r, 2'b00};
        end else begin
            o_dmem_raddr = '0;
        end
        o_dmem_wr_en = drain_s;
        if (drain_s) begin
            o_dmem_waddr = {sb_addr_r[head_r], 2'b00};
            o_dmem_wdata = sb_data_r[head_r];
        end else begin
            o_dmem_waddr = '0;
            o_dmem_wdata = '0;
        end
    end
endmodule

// File: tb/tb_ldst_unit.sv
// Bench for ldst_unit: store-buffer queue model, directed scenarios and random traffic.
module tb_ldst_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_issue_vld = 1'b0, i_is_st = 1'b0, i_flush = 1'b0;
    logic [31:0] i_rs1_srcopr = '0, i_rs2_srcopr = '0, i_imm = '0, i_dmem_rdata;
    logic [5:0]  i_rrftag = '0;
    logic [1:0]  i_com_st_num = '0;
    logic        o_issue_rdy, o_exfin_ld, o_exfin_st, o_dmem_rd_en, o_dmem_wr_en;
    logic [5:0]  o_ex_ld_rrftag, o_ex_st_rrftag;
    logic [31:0] o_exfin_ld_res, o_dmem_raddr, o_dmem_waddr, o_dmem_wdata;

    ldst_unit #(.DATA_W(32), .TAG_W(6), .SB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_issue_vld(i_issue_vld), .o_issue_rdy(o_issue_rdy),
        .i_rs1_srcopr(i_rs1_srcopr), .i_rs2_srcopr(i_rs2_srcopr), .i_imm(i_imm),
        .i_is_st(i_is_st), .i_rrftag(i_rrftag), .i_com_st_num(i_com_st_num), .i_flush(i_flush),
        .o_exfin_ld(o_exfin_ld), .o_ex_ld_rrftag(o_ex_ld_rrftag), .o_exfin_ld_res(o_exfin_ld_res),
        .o_exfin_st(o_exfin_st), .o_ex_st_rrftag(o_ex_st_rrftag),
        .o_dmem_rd_en(o_dmem_rd_en), .o_dmem_raddr(o_dmem_raddr), .i_dmem_rdata(i_dmem_rdata),
        .o_dmem_wr_en(o_dmem_wr_en), .o_dmem_waddr(o_dmem_waddr), .o_dmem_wdata(o_dmem_wdata)
    );

    always #5 clk = ~clk;

    // Data memory driven by the DUT: writes land at the edge, reads return next cycle
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (o_dmem_wr_en) mem[o_dmem_waddr[11:2]] <= o_dmem_wdata;
        if (o_dmem_rd_en) i_dmem_rdata <= mem[o_dmem_raddr[11:2]];
    end

    // Reference model: SB as a queue, oldest first; the first ccnt entries are committed
    typedef struct { logic [29:0] w; logic [31:0] d; } sbe_t;
    sbe_t        sbq[$];
    int          ccnt = 0;
    logic [31:0] ref_mem [1024];
    logic        p1_v = 1'b0, p2_v = 1'b0, pst_v = 1'b0;
    logic [29:0] p1_w = '0;
    logic [5:0]  p1_tag = '0, p2_tag = '0, pst_tag = '0;
    logic [31:0] p2_res = '0;
    bit          model_valid = 1'b0;

    bit          chk_en = 1'b0;
    logic        e_rdy, e_st, e_ld, e_rd, e_wr;
    logic [5:0]  e_st_tag, e_ld_tag;
    logic [31:0] e_ld_res, e_raddr, e_waddr, e_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("issue_rdy", 32'(o_issue_rdy), 32'(e_rdy));
            chk("exfin_st", 32'(o_exfin_st), 32'(e_st));
            if (e_st) chk("st_tag", 32'(o_ex_st_rrftag), 32'(e_st_tag));
            chk("exfin_ld", 32'(o_exfin_ld), 32'(e_ld));
            if (e_ld) begin
                chk("ld_tag", 32'(o_ex_ld_rrftag), 32'(e_ld_tag));
                chk("ld_res", o_exfin_ld_res, e_ld_res);
            end
            chk("rd_en", 32'(o_dmem_rd_en), 32'(e_rd));
            if (e_rd) chk("raddr", o_dmem_raddr, e_raddr);
            chk("wr_en", 32'(o_dmem_wr_en), 32'(e_wr));
            if (e_wr) begin
                chk("waddr", o_dmem_waddr, e_waddr);
                chk("wdata", o_dmem_wdata, e_wdata);
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic st, input logic [5:0] tg,
                        input logic [1:0] com, input logic fl, input logic rn);
        logic        hit, fire;
        logic [31:0] fwd, ea;
        @(posedge clk);
        #1;
        i_issue_vld = v; i_rs1_srcopr = r1; i_rs2_srcopr = r2; i_imm = im;
        i_is_st = st; i_rrftag = tg; i_com_st_num = com; i_flush = fl; rst_n = rn;
        ea = r1 + im;
        hit = 1'b0; fwd = '0;
        foreach (sbq[k]) if (sbq[k].w == p1_w) begin hit = 1'b1; fwd = sbq[k].d; end
        e_rdy = (sbq.size() < DEPTH) && !fl;
        e_st = pst_v; e_st_tag = pst_tag;
        e_ld = p2_v; e_ld_tag = p2_tag; e_ld_res = p2_res;
        e_rd = p1_v && !hit; e_raddr = {p1_w, 2'b00};
        e_wr = (ccnt > 0);
        e_waddr = e_wr ? {sbq[0].w, 2'b00} : '0;
        e_wdata = e_wr ? sbq[0].d : '0;
        chk_en = model_valid;
        @(negedge clk);
        #1;
        fire = rn && v && e_rdy;
        if (ccnt > 0) begin
            ref_mem[sbq[0].w[9:0]] = sbq[0].d;
            void'(sbq.pop_front());
            ccnt--;
        end
        p2_v = p1_v && !fl; p2_tag = p1_tag;
        p2_res = hit ? fwd : ref_mem[p1_w[9:0]];
        ccnt += int'(com);
        if (fl) while (sbq.size() > ccnt) void'(sbq.pop_back());
        pst_v = fire && st; pst_tag = tg;
        p1_v = fire && !st; p1_tag = tg; p1_w = ea[31:2];
        if (fire && st) sbq.push_back('{w: ea[31:2], d: r2});
        if (!rn) begin
            sbq.delete(); ccnt = 0;
            p1_v = 1'b0; p2_v = 1'b0; pst_v = 1'b0;
            model_valid = 1'b1;
        end
    endtask

    task automatic idle(input logic [1:0] com);
        step(1'b0, '0, '0, '0, 1'b0, 6'd0, com, 1'b0, 1'b1);
    endtask

    task automatic drain_all();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) begin
            int u = sbq.size() - ccnt;
            idle(2'(u >= 2 ? 2 : u));
        end
    endtask

    initial begin
        logic [31:0] pre;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h5A000000 ^ (i * 32'h00010101);
            ref_mem[i] = mem[i];
        end
        mem[32'h200 >> 2] = 32'h12345678;
        ref_mem[32'h200 >> 2] = 32'h12345678;

        step(1'b0, '0, '0, '0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
        idle(2'd0);
        chk("rst_rdy", 32'(o_issue_rdy), 32'd1);
        chk("rst_outs", {25'd0, o_exfin_ld, o_exfin_st, o_dmem_rd_en, o_dmem_wr_en, 3'd0}, 32'd0);

        // SW then LW at the same address forwards without touching memory
        step(1'b1, 32'h100, 32'hDEADBEEF, 32'd4, 1'b1, 6'd3, 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 32'd0, 32'd4, 1'b0, 6'd5, 2'd0, 1'b0, 1'b1);
        chk("sc1_st_tag", {26'd0, o_ex_st_rrftag}, 32'd3);
        idle(2'd0);
        chk("sc1_no_rd", 32'(o_dmem_rd_en), 32'd0);
        idle(2'd0);
        chk("sc1_ld_vld", 32'(o_exfin_ld), 32'd1);
        chk("sc1_ld_tag", {26'd0, o_ex_ld_rrftag}, 32'd5);
        chk("sc1_ld_res", o_exfin_ld_res, 32'hDEADBEEF);
        drain_all();

        // Load miss reads memory
        step(1'b1, 32'h1F0, 32'd0, 32'h10, 1'b0, 6'd7, 2'd0, 1'b0, 1'b1);
        idle(2'd0);
        chk("sc2_rd_en", 32'(o_dmem_rd_en), 32'd1);
        chk("sc2_raddr", o_dmem_raddr, 32'h200);
        idle(2'd0);
        chk("sc2_res", o_exfin_ld_res, 32'h12345678);

        // Youngest matching store wins; low address bits ignored
        step(1'b1, 32'h40, 32'd1, 32'd0, 1'b1, 6'd8, 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'h40, 32'd2, 32'd0, 1'b1, 6'd9, 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'h40, 32'd0, 32'd3, 1'b0, 6'd10, 2'd0, 1'b0, 1'b1);
        idle(2'd0);
        idle(2'd0);
        chk("sc3_res", o_exfin_ld_res, 32'd2);
        drain_all();

        // Fill the buffer, then commit two and watch in-order drain
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i), 32'd0, 1'b1, 6'(11 + i), 2'd0, 1'b0, 1'b1);
        idle(2'd0);
        chk("sc4_full", 32'(o_issue_rdy), 32'd0);
        idle(2'd2);
        chk("sc4_full2", 32'(o_issue_rdy), 32'd0);
        idle(2'd0);
        chk("sc4_wr1", o_dmem_waddr, 32'h80);
        chk("sc4_rdy_drain", 32'(o_issue_rdy), 32'd0);
        idle(2'd0);
        chk("sc4_wr2", o_dmem_waddr, 32'h84);
        chk("sc4_rdy_back", 32'(o_issue_rdy), 32'd1);
        idle(2'd0);
        chk("sc4_wr_done", 32'(o_dmem_wr_en), 32'd0);
        drain_all();

        // Flush discards uncommitted stores and the in-flight load
        pre = mem[32'hA4 >> 2];
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hA0 + 32'(4 * i), 32'h5550 + 32'(i), 32'd0, 1'b1, 6'(15 + i), 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'hA0, 32'd0, 32'd0, 1'b0, 6'd18, 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'hB0, 32'd0, 32'd0, 1'b1, 6'd19, 2'd1, 1'b1, 1'b1);
        chk("sc5_rdy_flush", 32'(o_issue_rdy), 32'd0);
        idle(2'd0);
        chk("sc5_no_ld", 32'(o_exfin_ld), 32'd0);
        chk("sc5_no_st", 32'(o_exfin_st), 32'd0);
        chk("sc5_wr_a0", o_dmem_waddr, 32'hA0);
        idle(2'd0);
        chk("sc5_wr_end", 32'(o_dmem_wr_en), 32'd0);
        idle(2'd0);
        chk("sc5_a4_kept", mem[32'hA4 >> 2], pre);

        // Reset while two committed stores wait to drain
        pre = mem[32'hC4 >> 2];
        step(1'b1, 32'hC0, 32'h77, 32'd0, 1'b1, 6'd20, 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'hC4, 32'h78, 32'd0, 1'b1, 6'd21, 2'd0, 1'b0, 1'b1);
        idle(2'd2);
        step(1'b0, '0, '0, '0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
        idle(2'd0);
        chk("sc6_rdy", 32'(o_issue_rdy), 32'd1);
        chk("sc6_outs", {25'd0, o_exfin_ld, o_exfin_st, o_dmem_rd_en, o_dmem_wr_en, 3'd0}, 32'd0);
        chk("sc6_wdata", o_dmem_wdata, 32'd0);
        idle(2'd0);
        chk("sc6_no_wr", 32'(o_dmem_wr_en), 32'd0);
        chk("sc6_c4_kept", mem[32'hC4 >> 2], pre);

        // Random traffic with commits, flushes, wrapped addresses and rare resets
        for (int c = 0; c < 2500; c++) begin
            int u;
            logic [31:0] r1, im;
            u = sbq.size() - ccnt;
            r1 = 32'($urandom_range(0, 127));
            im = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 15) == 0) begin
                r1 = 32'hFFFFFFF0;
                im = 32'($urandom_range(16, 100));
            end
            step($urandom_range(0, 3) != 0, r1, $urandom, im, 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)), 2'($urandom_range(0, (u >= 2) ? 2 : u)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 299) != 0);
        end
        idle(2'd0);
        idle(2'd0);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
